// File: rtl/peribus_timer.sv
// peribus_timer: 16-bit prescaled down-counter timer for the Peribus.
// Four word registers: CTRL, RELOAD, COUNT, STATUS. A held write strobe
// commits exactly once, on its first edge. irq = TF & IE.
module peribus_timer #(
  parameter int                    DATA_WIDTH    = 16,
  parameter int                    PRESCALE_BITS = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_RELOAD  = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic                  chipselect,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  irq
);

  // The prescaler must reach 2^PS-1 for the largest PS value.
  localparam int PW = (1 << PRESCALE_BITS) - 1;

  logic                     wstb, wstb_q, wr_commit;
  logic                     wr_ctrl, wr_reload, wr_count, wr_status;
  logic                     en_q, en_d, ie_q, ie_d, mode_q, mode_d, tf_q, tf_d;
  logic [PRESCALE_BITS-1:0] ps_q, ps_d;
  logic [DATA_WIDTH-1:0]    reload_q, reload_d, count_q, count_d;
  logic [PW-1:0]            pre_q, pre_d, pre_lim;
  logic                     tick;

  assign wstb      = chipselect & write_en;
  assign wr_commit = wstb & ~wstb_q;
  assign wr_ctrl   = wr_commit && (addr == 2'd0);
  assign wr_reload = wr_commit && (addr == 2'd1);
  assign wr_count  = wr_commit && (addr == 2'd2);
  assign wr_status = wr_commit && (addr == 2'd3);

  assign pre_lim = PW'((32'd1 << ps_q) - 32'd1);
  assign tick    = en_q && (pre_q == pre_lim);
  assign irq     = tf_q & ie_q;

  // Next-state: register writes, prescaler and the prioritised counter update.
  always_comb begin
    en_d     = en_q;
    ie_d     = ie_q;
    mode_d   = mode_q;
    ps_d     = ps_q;
    reload_d = reload_q;
    count_d  = count_q;
    pre_d    = pre_q;
    tf_d     = tf_q;

    if (en_q) pre_d = tick ? '0 : pre_q + PW'(1);

    if (wr_ctrl) begin
      en_d   = write_data[0];
      ie_d   = write_data[1];
      mode_d = write_data[2];
      ps_d   = write_data[4 +: PRESCALE_BITS];
      pre_d  = '0;
    end
    if (wr_reload) reload_d = write_data;
    // W1C comes first so a same-edge timeout below overrides it.
    if (wr_status && write_data[0]) tf_d = 1'b0;

    if (wr_count) begin
      count_d = write_data;
      pre_d   = '0;
    end else if (wr_ctrl && write_data[0] && !en_q) begin
      count_d = reload_q;
    end else if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - DATA_WIDTH'(1);
      end else begin
        tf_d = 1'b1;
        if (!mode_q)      count_d = reload_q;
        // An explicit CTRL write on the expiry edge keeps its EN value.
        else if (!wr_ctrl) en_d   = 1'b0;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wstb_q   <= 1'b0;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      mode_q   <= 1'b0;
      ps_q     <= '0;
      reload_q <= RESET_RELOAD;
      count_q  <= '0;
      pre_q    <= '0;
      tf_q     <= 1'b0;
    end else begin
      wstb_q   <= wstb;
      en_q     <= en_d;
      ie_q     <= ie_d;
      mode_q   <= mode_d;
      ps_q     <= ps_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      pre_q    <= pre_d;
      tf_q     <= tf_d;
    end
  end

  // Combinational read mux; zero unless selected for read.
  always_comb begin
    read_data = '0;
    if (chipselect && read_en) begin
      case (addr)
        2'd0:    read_data = DATA_WIDTH'({ps_q, 1'b0, mode_q, ie_q, en_q});
        2'd1:    read_data = reload_q;
        2'd2:    read_data = count_q;
        default: read_data = DATA_WIDTH'({en_q, tf_q});
      endcase
    end
  end

endmodule

// File: tb/tb_peribus_timer.sv
// Directed bench for peribus_timer: reset, periodic, W1C, one-shot,
// strobe edge detection, IE masking and chipselect decode.
module tb_peribus_timer;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [15:0] write_data;
  logic        write_en, read_en, chipselect;
  logic [15:0] read_data;
  logic        irq;

  int checks = 0;
  int errors = 0;

  peribus_timer dut (
    .clock(clock), .reset(reset), .addr(addr), .write_data(write_data),
    .write_en(write_en), .read_en(read_en), .chipselect(chipselect),
    .read_data(read_data), .irq(irq)
  );

  always #5 clock = ~clock;

  // Advance one rising edge, then settle 1ns past it.
  task automatic step();
    @(posedge clock); #1;
  endtask

  // One-edge write pulse; caller leaves an idle edge before the next write.
  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clock);
    chipselect = 1'b1; write_en = 1'b1; addr = a; write_data = d;
    @(posedge clock); #1;
    chipselect = 1'b0; write_en = 1'b0;
  endtask

  // Combinational read between edges.
  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    chipselect = 1'b1; read_en = 1'b1; addr = a;
    #1 d = read_data;
    chipselect = 1'b0; read_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b1; addr = '0; write_data = '0;
    write_en = 1'b0; read_en = 1'b0; chipselect = 1'b0;
    #2;
    rd(2'd2, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL por_count got %h exp 0000", v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL por_irq got %b exp 0", irq); end
    @(negedge clock); reset = 1'b0;
    step();
    wr(2'd1, 16'd100); step();
    wr(2'd0, 16'h0003); step(); step(); step();
    rd(2'd2, v);
    checks++; if (v !== 16'd97) begin errors++; $display("FAIL pre_reset_count got %0d exp 97", v); end
    reset = 1'b1; #1;
    rd(2'd2, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rst_count got %h exp 0000", v); end
    rd(2'd0, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rst_ctrl got %h exp 0000", v); end
    rd(2'd3, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rst_status got %h exp 0000", v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
    reset = 1'b0; #1;
    checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL rst_rdata_nocs got %h exp 0000", read_data); end
  endtask

  task automatic test_periodic();
    logic [15:0] v;
    step();
    wr(2'd1, 16'd3); step();
    wr(2'd0, 16'h0003);
    for (int i = 0; i < 4; i++) begin
      rd(2'd2, v);
      checks++; if (v !== 16'(3 - i)) begin errors++; $display("FAIL per_count[%0d] got %0d exp %0d", i, v, 3 - i); end
      if (i < 3) step();
    end
    rd(2'd3, v);
    checks++; if (v[0] !== 1'b0) begin errors++; $display("FAIL per_tf_early got %b exp 0", v[0]); end
    step();
    rd(2'd3, v);
    checks++; if (v !== 16'h0003) begin errors++; $display("FAIL per_status got %h exp 0003", v); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL per_irq got %b exp 1", irq); end
    rd(2'd2, v);
    checks++; if (v !== 16'd3) begin errors++; $display("FAIL per_reload got %0d exp 3", v); end
    step(); step(); step();
    rd(2'd2, v);
    checks++; if (v !== 16'd0) begin errors++; $display("FAIL per2_zero got %0d exp 0", v); end
    step();
    rd(2'd2, v);
    checks++; if (v !== 16'd3) begin errors++; $display("FAIL per2_reload got %0d exp 3", v); end
  endtask

  task automatic test_w1c();
    logic [15:0] v;
    wr(2'd3, 16'h0001);
    rd(2'd3, v);
    checks++; if (v !== 16'h0002) begin errors++; $display("FAIL w1c_status got %h exp 0002", v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got %b exp 0", irq); end
    step(); step();
    rd(2'd2, v);
    checks++; if (v !== 16'd0) begin errors++; $display("FAIL w1c_pre_zero got %0d exp 0", v); end
    wr(2'd3, 16'h0001);
    rd(2'd3, v);
    checks++; if (v !== 16'h0003) begin errors++; $display("FAIL w1c_set_wins got %h exp 0003", v); end
    rd(2'd2, v);
    checks++; if (v !== 16'd3) begin errors++; $display("FAIL w1c_set_count got %0d exp 3", v); end
  endtask

  task automatic test_oneshot();
    logic [15:0] v;
    step();
    wr(2'd0, 16'h0000); step();
    wr(2'd3, 16'h0001); step();
    wr(2'd1, 16'd1);    step();
    wr(2'd0, 16'h0027);
    step(); step(); step();
    rd(2'd2, v);
    checks++; if (v !== 16'd1) begin errors++; $display("FAIL os_count3 got %0d exp 1", v); end
    step();
    rd(2'd2, v);
    checks++; if (v !== 16'd0) begin errors++; $display("FAIL os_count4 got %0d exp 0", v); end
    step(); step(); step();
    rd(2'd3, v);
    checks++; if (v !== 16'h0002) begin errors++; $display("FAIL os_status7 got %h exp 0002", v); end
    step();
    rd(2'd3, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL os_status8 got %h exp 0001", v); end
    rd(2'd0, v);
    checks++; if (v !== 16'h0026) begin errors++; $display("FAIL os_ctrl got %h exp 0026", v); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL os_irq got %b exp 1", irq); end
    for (int i = 0; i < 10; i++) step();
    rd(2'd2, v);
    checks++; if (v !== 16'd0) begin errors++; $display("FAIL os_hold got %0d exp 0", v); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    step();
    wr(2'd3, 16'h0001); step();
    wr(2'd0, 16'h0001); step();
    @(negedge clock);
    chipselect = 1'b1; write_en = 1'b1; read_en = 1'b1; addr = 2'd2; write_data = 16'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (read_data !== 16'(5 - i)) begin errors++; $display("FAIL hold_count[%0d] got %0d exp %0d", i, read_data, 5 - i); end
    end
    chipselect = 1'b0; write_en = 1'b0; read_en = 1'b0;
    rd(2'd3, v);
    checks++; if (v !== 16'h0002) begin errors++; $display("FAIL hold_status got %h exp 0002", v); end
  endtask

  task automatic test_mask_decode();
    logic [15:0] v;
    step(); step(); step(); step();
    rd(2'd3, v);
    checks++; if (v !== 16'h0003) begin errors++; $display("FAIL mask_status got %h exp 0003", v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq got %b exp 0", irq); end
    wr(2'd0, 16'h0002);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ie_irq got %b exp 1", irq); end
    rd(2'd0, v);
    checks++; if (v !== 16'h0002) begin errors++; $display("FAIL ie_ctrl got %h exp 0002", v); end
    step();
    @(negedge clock);
    chipselect = 1'b0; write_en = 1'b1; addr = 2'd1; write_data = 16'hBEEF;
    step();
    write_en = 1'b0;
    rd(2'd1, v);
    checks++; if (v !== 16'd1) begin errors++; $display("FAIL nocs_reload got %h exp 0001", v); end
    chipselect = 1'b1; read_en = 1'b0; addr = 2'd1; #1;
    checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL nore_rdata got %h exp 0000", read_data); end
    chipselect = 1'b0;
    step();
    wr(2'd0, 16'h0000);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ie_clr_irq got %b exp 0", irq); end
    rd(2'd3, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL ie_clr_tf got %h exp 0001", v); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_w1c();
    test_oneshot();
    test_back_to_back();
    test_mask_decode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/peribus_timer.md
Name: peribus_timer

Overview:
- 16-bit prescaled down-counter timer peripheral on the Peribus.
- Sits directly downstream of the Peribus controller, which drives addr[1:0], write_data, the strobes and this block's chipselect line.
- Consumes the controller's decode and returns read_data and irq. It fills the TIMER_0 (base 0x8) and TIMER_1 (base 0xC) slots, 4 words each.

Parameters:
- DATA_WIDTH, 16, bus word and counter width; only 16 supported.
- PRESCALE_BITS, 4, width of CTRL.PS field; prescale divisor is 2^PS.
- RESET_RELOAD, 16'h0000, reset value of RELOAD.

Ports:
- clock  input  1  Peribus clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  2  register select.
- write_data  input  16  write data.
- write_en  input  1  level write strobe from the controller, asynchronous to the CPU side.
- read_en  input  1  level read strobe.
- chipselect  input  1  block selected by the controller decode.
- read_data  output  16  register read data.
- irq  output  1  interrupt request to the controller OR tree.

Behaviour:
Register map:
- 0 CTRL: bit0 EN, bit1 IE, bit2 MODE (0 periodic, 1 one-shot), bits[7:4] PS. Bits[15:8] and bit3 read 0.
- 1 RELOAD: R/W, 16 bits.
- 2 COUNT: read returns the current count; a write loads count.
- 3 STATUS: bit0 TF (timeout flag), write-1-to-clear; bit1 RUN (read-only, equals EN). Other bits read 0.

Reset (async, immediate, no clock needed):
- CTRL=0, RELOAD=RESET_RELOAD, count=0, prescaler=0, TF=0, strobe history=0.
- Outputs: read_data=0, irq=0.

Writes:
- Strobe is wstb = chipselect & write_en, registered every edge into wstb_q.
- A write commits only on an edge where wstb=1 and wstb_q=0. Holding write_en for N cycles yields exactly one write.
- Writes with chipselect=0 are ignored.

Reads:
- read_data is combinational: the addressed register when chipselect & read_en, else 16'h0000.
- Reads have no side effects.

Prescaler:
- tick=1 on an edge where EN=1 and prescaler == 2^PS-1; the prescaler then returns to 0, otherwise it increments while EN=1.
- PS=0 means tick every clock.
- Any CTRL write clears the prescaler.

Counter, per edge, highest priority first:
1. COUNT write: count<=write_data; prescaler<=0.
2. CTRL write with EN 0->1: count<=RELOAD; prescaler<=0.
3. Tick with count != 0: count<=count-1.
4. Tick with count == 0:
   - TF<=1.
   - Periodic: count<=RELOAD.
   - One-shot: count stays 0 and EN<=0.
- Timeout period is (RELOAD+1)*2^PS clocks after enable.

Other rules:
- An EN 1->0 write freezes count; no tick occurs while EN=0.
- A RELOAD write while running takes effect at the next reload only.
- TF set and TF W1C on the same edge: set wins, TF stays 1.
- irq = TF & IE. It is combinational from registers, so it rises in the cycle TF sets. Clearing IE masks irq but not TF.
- RELOAD=0, periodic: timeout every 2^PS clocks.
- count never wraps below 0.

Test Plan:
1. Reset: assert reset mid-count with no clock edge -> count, CTRL and TF read 0 immediately; irq=0. Deassert reset -> read_data=0 while chipselect=0.
2. Periodic: RELOAD=3, write CTRL=0x0003 -> COUNT reads 3,2,1,0 on successive edges. TF=1 and irq=1 on the 4th edge after the enable write, with COUNT=3. Period repeats every 4 clocks.
3. W1C: with TF=1, write STATUS=0x0001 -> TF=0 and irq=0 next edge. Repeat the W1C on the exact edge count hits 0 -> TF remains 1.
4. One-shot, prescaled: RELOAD=1, CTRL=0x0027 (PS=2) -> COUNT=0 after 4 clocks. TF=1 after 8 clocks; CTRL reads 0x0026, STATUS reads 0x0001, COUNT holds 0 forever.
5. Strobe edge detect: running with PS=0, hold write_en with chipselect for 3 clocks writing COUNT=5 -> COUNT reads 5, then 4, 3 while the strobe is still held. Exactly one write committed.
6. Mask/decode: IE=0 with timeout -> TF=1, irq=0. Set IE=1 -> irq=1 immediately. Write with chipselect=0 -> no register change; read with read_en=0 -> 0x0000.
